// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared Jump King motion types and screen constants
package jk_pkg;

  typedef enum logic [1:0] {GROUND, CHARGE, AIR} motion_state_t;

  localparam int SCREEN_W = 800;
  localparam int SCREEN_H = 600;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running divider, one-clk tick every TICK_CLKS cycles
module tick_gen #(
  parameter int TICK_CLKS = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_CLKS > 2) ? $clog2(TICK_CLKS) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_CLKS - 1));

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/player_motion_ctl.sv
// rtl/player_motion_ctl.sv - Jump King player motion: walk, charge, ballistic flight, bounce, landing
module player_motion_ctl #(
  parameter int SCREEN_W     = jk_pkg::SCREEN_W,
  parameter int SCREEN_H     = jk_pkg::SCREEN_H,
  parameter int RECT_W       = 64,
  parameter int RECT_H       = 64,
  parameter int X_START      = 0,
  parameter int TICK_CLKS    = 1_000_000,
  parameter int GRAVITY      = 1,
  parameter int VY_TERMINAL  = 16,
  parameter int WALK_SPEED   = 2,
  parameter int JUMP_VX      = 6,
  parameter int JUMP_VY_MIN  = 4,
  parameter int JUMP_VY_MAX  = 20,
  parameter int CHARGE_MAX   = 63,
  parameter int CHARGE_SHIFT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_space,
  input  logic        key_left,
  input  logic        key_right,
  output logic [11:0] value_x,
  output logic [11:0] value_y,
  output logic        airborne,
  output logic        charging,
  output logic [7:0]  charge_level,
  output logic        landed
);

  import jk_pkg::*;

  localparam int FLOOR = SCREEN_H - RECT_H;
  localparam int XMAX  = SCREEN_W - RECT_W;

  localparam logic signed [13:0] FLOOR_S = 14'(FLOOR);
  localparam logic signed [13:0] XMAX_S  = 14'(XMAX);
  localparam logic signed [13:0] VT_S    = 14'(VY_TERMINAL);
  localparam logic signed [13:0] G_S     = 14'(GRAVITY);
  localparam logic signed [13:0] WALK_S  = 14'(WALK_SPEED);
  localparam logic signed [7:0]  JVX_S   = 8'(JUMP_VX);

  motion_state_t     state, state_n;
  logic [11:0]       x, x_n, y, y_n;
  logic signed [7:0] vx, vx_n, vy, vy_n;
  logic [7:0]        charge, charge_n;
  logic              landed_q, landed_n;
  logic              tick;

  logic signed [13:0] xs, ys, vxs, vys, xn, yn, vyg, x_left, x_right;
  logic [7:0]         lv_raw, lv;
  logic               left_only, right_only;

  tick_gen #(.TICK_CLKS(TICK_CLKS)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign left_only  = key_left & ~key_right;
  assign right_only = key_right & ~key_left;

  // All motion arithmetic in signed 14 bits so under/overflow is visible before clamping.
  assign xs      = $signed({2'b00, x});
  assign ys      = $signed({2'b00, y});
  assign vxs     = $signed({{6{vx[7]}}, vx});
  assign vys     = $signed({{6{vy[7]}}, vy});
  assign xn      = xs + vxs;
  assign yn      = ys + vys;
  assign vyg     = vys + G_S;
  assign x_left  = xs - WALK_S;
  assign x_right = xs + WALK_S;
  assign lv_raw  = 8'(JUMP_VY_MIN) + (charge >> CHARGE_SHIFT);
  assign lv      = (lv_raw > 8'(JUMP_VY_MAX)) ? 8'(JUMP_VY_MAX) : lv_raw;

  always_comb begin
    state_n  = state;
    x_n      = x;
    y_n      = y;
    vx_n     = vx;
    vy_n     = vy;
    charge_n = charge;
    landed_n = 1'b0;
    if (tick) begin
      case (state)
        GROUND: begin
          if (key_space) begin
            state_n  = CHARGE;
            charge_n = '0;
          end else if (left_only) begin
            x_n = (x_left < 0) ? 12'd0 : x_left[11:0];
          end else if (right_only) begin
            x_n = (x_right > XMAX_S) ? 12'(XMAX) : x_right[11:0];
          end
        end
        CHARGE: begin
          if (key_space) begin
            if (charge < 8'(CHARGE_MAX)) charge_n = charge + 8'd1;
          end else begin
            state_n  = AIR;
            vy_n     = -lv;
            vx_n     = left_only ? -JVX_S : (right_only ? JVX_S : 8'sd0);
            charge_n = '0;
          end
        end
        AIR: begin
          if (xn < 0) begin
            x_n  = 12'd0;
            vx_n = -vx;
          end else if (xn > XMAX_S) begin
            x_n  = 12'(XMAX);
            vx_n = -vx;
          end else begin
            x_n = xn[11:0];
          end
          // Landing overrides any wall-bounce vx from the same tick.
          if (yn < 0) begin
            y_n  = 12'd0;
            vy_n = 8'sd0;
          end else if (yn >= FLOOR_S) begin
            y_n      = 12'(FLOOR);
            vx_n     = 8'sd0;
            vy_n     = 8'sd0;
            state_n  = GROUND;
            landed_n = 1'b1;
          end else begin
            y_n  = yn[11:0];
            vy_n = (vyg > VT_S) ? VT_S[7:0] : vyg[7:0];
          end
        end
        default: state_n = GROUND;
      endcase
    end
  end

  always_comb begin
    value_x      = x;
    value_y      = y;
    airborne     = (state == AIR);
    charging     = (state == CHARGE);
    charge_level = (state == CHARGE) ? charge : 8'd0;
    landed       = landed_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= GROUND;
      x        <= 12'(X_START);
      y        <= 12'(FLOOR);
      vx       <= '0;
      vy       <= '0;
      charge   <= '0;
      landed_q <= 1'b0;
    end else begin
      state    <= state_n;
      x        <= x_n;
      y        <= y_n;
      vx       <= vx_n;
      vy       <= vy_n;
      charge   <= charge_n;
      landed_q <= landed_n;
    end
  end

endmodule
